seq_complement_unit: RTL

- Parametrised, digit-serial complement engine. Next generation of the team's 8-bit ripple two's-complement negator.
- Processes a WIDTH-bit operand DIGIT bits per clock, LSB digit first.
- Supports four modes: pass, ones' complement, two's negate, absolute value.
- Reports overflow on the most-negative input.
- Sits in the adder/ALU datapath behind a valid/ready handshake on both sides, so it can be shared between producers.

---
 rtl/seq_complement_unit_pkg.sv | 26 ++
 rtl/seq_complement_unit_complement_digit_stage.sv | 35 +++
 rtl/seq_complement_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_complement_unit_pkg.sv
// Shared definitions for the digit-serial complement engine: mode codes,
// FSM state encoding and configuration helpers.
package seq_complement_unit_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ONES = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit size must tile the operand exactly.
  function automatic bit cfg_legal(input int width, input int digit);
    if (width < 2 || digit < 1 || digit > width) return 1'b0;
    return (width % digit) == 0;
  endfunction

endpackage

// File: rtl/seq_complement_unit_complement_digit_stage.sv
// One digit slice: conditional inverter followed by a ripple increment chain
// that adds the incoming single-bit carry.
module complement_digit_stage
  import seq_complement_unit_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] digit,
  input  logic             invert,
  input  logic             carry_in,
  output logic [DIGIT-1:0] sum,
  output logic             carry_out
);

  logic [DIGIT-1:0] operand;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_inv
      assign operand[gi] = digit[gi] ^ invert;
    end
  endgenerate

  // Only a one-bit addend enters the chain, so each cell is a half adder.
  always_comb begin
    logic c;
    c   = carry_in;
    sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i] = operand[i] ^ c;
      c      = operand[i] & c;
    end
    carry_out = c;
  end

endmodule

// File: rtl/seq_complement_unit.sv
// Digit-serial pass / ones' complement / negate / absolute-value unit with
// valid/ready handshakes on both sides; LSB digit processed first.
module seq_complement_unit
  import seq_complement_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  generate
    if (!cfg_legal(WIDTH, DIGIT)) begin : g_cfg_check
      $error("seq_complement_unit: DIGIT must divide WIDTH and WIDTH must be >= 2");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] operand_reg;
  logic [WIDTH-1:0] result_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             invert_reg;
  logic             ovf_reg;

  logic             start_invert, start_carry, start_ovf;
  logic [31:0]      shamt;
  logic [DIGIT-1:0] digit_cur, digit_sum;
  logic             digit_carry;
  logic [WIDTH-1:0] digit_placed;

  // Only negative operands are negated in absolute-value mode.
  assign start_invert = (in_mode == MODE_ONES) || (in_mode == MODE_NEG) ||
                        ((in_mode == MODE_ABS) && in_data[WIDTH-1]);
  assign start_carry  = (in_mode == MODE_NEG) ||
                        ((in_mode == MODE_ABS) && in_data[WIDTH-1]);
  assign start_ovf    = ((in_mode == MODE_NEG) || (in_mode == MODE_ABS)) &&
                        (in_data == MIN_NEG);

  assign shamt        = 32'(cnt_reg) * 32'(DIGIT);
  assign digit_cur    = DIGIT'(operand_reg >> shamt);
  assign digit_placed = WIDTH'(digit_sum) << shamt;

  complement_digit_stage #(
    .DIGIT (DIGIT)
  ) u_stage (
    .digit     (digit_cur),
    .invert    (invert_reg),
    .carry_in  (carry_reg),
    .sum       (digit_sum),
    .carry_out (digit_carry)
  );

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      operand_reg <= '0;
      result_reg  <= '0;
      cnt_reg     <= '0;
      carry_reg   <= 1'b0;
      invert_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            operand_reg <= in_data;
            result_reg  <= '0;
            cnt_reg     <= '0;
            carry_reg   <= start_carry;
            invert_reg  <= start_invert;
            ovf_reg     <= start_ovf;
          end
        end
        CALC: begin
          // Result starts cleared, so OR-ing each digit into place is enough.
          result_reg <= result_reg | digit_placed;
          carry_reg  <= digit_carry;
          cnt_reg    <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = result_reg;
  assign out_ovf  = ovf_reg;

endmodule
